// File: rtl/i2c_gpio_expander_pkg.sv
`default_nettype none
// ============================================================================
// Package  : i2c_gpio_pkg
// Purpose  : Shared types and constants for the I2C GPIO expander: FSM state
//            encoding, register-kind codes and command-pointer field helpers.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package i2c_gpio_pkg;

   localparam int MAX_BANKS = 4;

   // Register kinds selected by ptr[3:2]
   localparam logic [1:0] KIND_INPUT    = 2'd0;
   localparam logic [1:0] KIND_OUTPUT   = 2'd1;
   localparam logic [1:0] KIND_POLARITY = 2'd2;
   localparam logic [1:0] KIND_CONFIG   = 2'd3;

   // Slave protocol FSM encoding
   typedef logic [3:0] state_t;
   localparam logic [3:0] ST_IDLE      = 4'd0;
   localparam logic [3:0] ST_ADDR      = 4'd1;
   localparam logic [3:0] ST_ADDR_ACK  = 4'd2;
   localparam logic [3:0] ST_PTR       = 4'd3;
   localparam logic [3:0] ST_PTR_ACK   = 4'd4;
   localparam logic [3:0] ST_WDATA     = 4'd5;
   localparam logic [3:0] ST_WDATA_ACK = 4'd6;
   localparam logic [3:0] ST_RDATA     = 4'd7;
   localparam logic [3:0] ST_RDATA_ACK = 4'd8;

   function automatic logic [1:0] ptr_kind(input logic [7:0] p);
      return p[3:2];
   endfunction

   function automatic logic [1:0] ptr_bank(input logic [7:0] p);
      return p[1:0];
   endfunction

   // A pointer addresses a real register only if the reserved nibble is
   // clear and the bank exists in this configuration.
   function automatic logic ptr_valid(input logic [7:0] p, input int nb);
      return (p[7:4] == 4'h0) && (int'(p[1:0]) < nb) && (nb <= MAX_BANKS);
   endfunction

endpackage
`default_nettype wire

// File: rtl/i2c_gpio_expander_bus_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : i2c_bus_conditioner
// Purpose  : Synchronises and glitch-filters SCL/SDA, then derives one-clock
//            event pulses for the I2C slave FSM.
// Ports    : clk, rst (sync, active low), scl_i/sda_i raw pads,
//            scl_rise_o/scl_fall_o/start_det_o/stop_det_o pulses,
//            sda_s_o filtered SDA level.
// Revision : 1.0 - initial release
// ============================================================================
module i2c_bus_conditioner #(
   parameter int FILTER_LEN = 3          // must be >= 2
) (
   input  logic clk,
   input  logic rst,
   input  logic scl_i,
   input  logic sda_i,
   output logic scl_rise_o,
   output logic scl_fall_o,
   output logic start_det_o,
   output logic stop_det_o,
   output logic sda_s_o
);

   // Bit 1 = SCL, bit 0 = SDA throughout
   logic [1:0]                  sync1_q, sync2_q, filt_q;
   logic [FILTER_LEN-2:0][1:0]  hist_q;
   logic [1:0]                  w_eq, w_filt_d;

   // A level is accepted only when the newest sample and all history agree.
   always_comb begin
      w_eq = 2'b11;
      for (int i = 0; i < FILTER_LEN-1; i++) begin
         w_eq = w_eq & ~(sync2_q ^ hist_q[i]);
      end
      w_filt_d = (w_eq & sync2_q) | (~w_eq & filt_q);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         sync1_q     <= 2'b11;
         sync2_q     <= 2'b11;
         hist_q      <= '1;
         filt_q      <= 2'b11;
         scl_rise_o  <= 1'b0;
         scl_fall_o  <= 1'b0;
         start_det_o <= 1'b0;
         stop_det_o  <= 1'b0;
      end else begin
         sync1_q   <= {scl_i, sda_i};
         sync2_q   <= sync1_q;
         hist_q[0] <= sync2_q;
         for (int i = 1; i < FILTER_LEN-1; i++) begin
            hist_q[i] <= hist_q[i-1];
         end
         filt_q      <= w_filt_d;
         // Pulses align with the cycle in which filt_q shows the new level
         scl_rise_o  <= ~filt_q[1] &  w_filt_d[1];
         scl_fall_o  <=  filt_q[1] & ~w_filt_d[1];
         start_det_o <=  filt_q[1] &  w_filt_d[1] &  filt_q[0] & ~w_filt_d[0];
         stop_det_o  <=  filt_q[1] &  w_filt_d[1] & ~filt_q[0] &  w_filt_d[0];
      end
   end

   assign sda_s_o = filt_q[0];

endmodule
`default_nettype wire

// File: rtl/i2c_gpio_expander.sv
`default_nettype none
// ============================================================================
// Module   : i2c_gpio_expander
// Purpose  : I2C-slave GPIO expander with 1..4 banks of 8 pins, auto-incrementing
//            register pointer, pin-selected address and change interrupt.
// Ports    : clk, rst (sync, active low), scl_i, sda_i, sda_oe (1 = pull low),
//            addr_pins (latched in reset), gpio_i, gpio_o, gpio_oe, int_n.
// Revision : 1.0 - initial release
// ============================================================================
module i2c_gpio_expander
   import i2c_gpio_pkg::*;
#(
   parameter int         N_BANKS     = 2,
   parameter logic [3:0] DEV_ADDR_HI = 4'h4,
   parameter int         FILTER_LEN  = 3
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 scl_i,
   input  logic                 sda_i,
   output logic                 sda_oe,
   input  logic [2:0]           addr_pins,
   input  logic [8*N_BANKS-1:0] gpio_i,
   output logic [8*N_BANKS-1:0] gpio_o,
   output logic [8*N_BANKS-1:0] gpio_oe,
   output logic                 int_n
);

   localparam int NP = 8*N_BANKS;

   logic w_scl_rise, w_scl_fall, w_start, w_stop, w_sda;

   i2c_bus_conditioner #(.FILTER_LEN(FILTER_LEN)) u_cond (
      .clk         (clk),
      .rst         (rst),
      .scl_i       (scl_i),
      .sda_i       (sda_i),
      .scl_rise_o  (w_scl_rise),
      .scl_fall_o  (w_scl_fall),
      .start_det_o (w_start),
      .stop_det_o  (w_stop),
      .sda_s_o     (w_sda)
   );

   // ---------------- GPIO input conditioning ----------------
   logic [NP-1:0]                 gsync1_q, gsync2_q, gfilt_q, w_geq, w_gfilt_d;
   logic [FILTER_LEN-2:0][NP-1:0] ghist_q;

   always_comb begin
      w_geq = '1;
      for (int i = 0; i < FILTER_LEN-1; i++) begin
         w_geq = w_geq & ~(gsync2_q ^ ghist_q[i]);
      end
      w_gfilt_d = (w_geq & gsync2_q) | (~w_geq & gfilt_q);
   end

   // The pipeline keeps running in reset so the snapshot taken at reset
   // reflects the real pins; the filter simply tracks the synchroniser then.
   always_ff @(posedge clk) begin
      gsync1_q   <= gpio_i;
      gsync2_q   <= gsync1_q;
      ghist_q[0] <= gsync2_q;
      for (int i = 1; i < FILTER_LEN-1; i++) begin
         ghist_q[i] <= ghist_q[i-1];
      end
      gfilt_q <= (!rst) ? gsync2_q : w_gfilt_d;
   end

   // ---------------- Registers ----------------
   state_t                    state_q, state_d;
   logic [3:0]                bit_cnt_q, bit_cnt_d;
   logic [7:0]                shift_q, shift_d;
   logic                      rw_q, rw_d;
   logic                      mack_q, mack_d;
   logic [7:0]                ptr_q, ptr_d;
   logic                      sda_oe_q, sda_oe_d;
   logic [2:0]                addr_q;
   logic [N_BANKS-1:0][7:0]   out_q, out_d, pol_q, pol_d, cfg_q, cfg_d;
   logic [NP-1:0]             snap_q, snap_d, w_cfg_flat;
   logic                      int_n_q;

   logic       w_valid, w_load;
   logic [1:0] w_kind, w_bank, w_bank_nxt;
   logic [7:0] w_rd_byte, w_ptr_inc;

   // Read mux and pointer increment
   always_comb begin
      w_valid   = ptr_valid(ptr_q, N_BANKS);
      w_kind    = ptr_kind(ptr_q);
      w_bank    = ptr_bank(ptr_q);
      w_rd_byte = 8'hFF;
      for (int b = 0; b < N_BANKS; b++) begin
         if (w_valid && (w_bank == 2'(b))) begin
            case (w_kind)
               KIND_INPUT:    w_rd_byte = gfilt_q[8*b +: 8] ^ pol_q[b];
               KIND_OUTPUT:   w_rd_byte = out_q[b];
               KIND_POLARITY: w_rd_byte = pol_q[b];
               default:       w_rd_byte = cfg_q[b];
            endcase
         end
      end
      if (int'(w_bank) + 1 >= N_BANKS) w_bank_nxt = 2'd0;
      else                             w_bank_nxt = w_bank + 2'd1;
      w_ptr_inc = {ptr_q[7:2], w_bank_nxt};
   end

   // Protocol FSM
   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;
      rw_d      = rw_q;
      mack_d    = mack_q;
      ptr_d     = ptr_q;
      sda_oe_d  = sda_oe_q;
      out_d     = out_q;
      pol_d     = pol_q;
      cfg_d     = cfg_q;
      snap_d    = snap_q;
      w_load    = 1'b0;

      if (w_start) begin
         state_d   = ST_ADDR;
         bit_cnt_d = 4'd0;
         sda_oe_d  = 1'b0;
      end else if (w_stop) begin
         state_d  = ST_IDLE;
         sda_oe_d = 1'b0;
      end else if (w_scl_rise) begin
         case (state_q)
            ST_ADDR, ST_PTR, ST_WDATA: begin
               if (bit_cnt_q < 4'd8) begin
                  shift_d   = {shift_q[6:0], w_sda};
                  bit_cnt_d = bit_cnt_q + 4'd1;
               end
            end
            ST_RDATA:     if (bit_cnt_q < 4'd8) bit_cnt_d = bit_cnt_q + 4'd1;
            ST_RDATA_ACK: mack_d = w_sda;
            default: ;
         endcase
      end else if (w_scl_fall) begin
         case (state_q)
            ST_ADDR: begin
               if (bit_cnt_q == 4'd8) begin
                  if ((shift_q[7:1] == {DEV_ADDR_HI, addr_q}) && (shift_q[7:1] != 7'h00)) begin
                     state_d  = ST_ADDR_ACK;
                     sda_oe_d = 1'b1;
                     rw_d     = shift_q[0];
                  end else begin
                     state_d  = ST_IDLE;
                     sda_oe_d = 1'b0;
                  end
               end
            end
            ST_ADDR_ACK: begin
               bit_cnt_d = 4'd0;
               if (rw_q) begin
                  state_d = ST_RDATA;
                  w_load  = 1'b1;
               end else begin
                  state_d  = ST_PTR;
                  sda_oe_d = 1'b0;
               end
            end
            ST_PTR: begin
               if (bit_cnt_q == 4'd8) begin
                  state_d  = ST_PTR_ACK;
                  sda_oe_d = 1'b1;
                  ptr_d    = shift_q;
               end
            end
            ST_PTR_ACK, ST_WDATA_ACK: begin
               // Data is committed on the fall that ends its ACK clock
               if (state_q == ST_WDATA_ACK) begin
                  for (int b = 0; b < N_BANKS; b++) begin
                     if (w_valid && (w_bank == 2'(b))) begin
                        case (w_kind)
                           KIND_OUTPUT:   out_d[b] = shift_q;
                           KIND_POLARITY: pol_d[b] = shift_q;
                           KIND_CONFIG:   cfg_d[b] = shift_q;
                           default: ;
                        endcase
                     end
                  end
                  ptr_d = w_ptr_inc;
               end
               state_d   = ST_WDATA;
               sda_oe_d  = 1'b0;
               bit_cnt_d = 4'd0;
            end
            ST_WDATA: begin
               if (bit_cnt_q == 4'd8) begin
                  state_d  = ST_WDATA_ACK;
                  sda_oe_d = 1'b1;
               end
            end
            ST_RDATA: begin
               if (bit_cnt_q == 4'd8) begin
                  state_d  = ST_RDATA_ACK;
                  sda_oe_d = 1'b0;
                  ptr_d    = w_ptr_inc;
               end else begin
                  shift_d  = {shift_q[6:0], 1'b1};
                  sda_oe_d = ~shift_q[6];
               end
            end
            ST_RDATA_ACK: begin
               if (!mack_q) begin
                  state_d   = ST_RDATA;
                  bit_cnt_d = 4'd0;
                  w_load    = 1'b1;
               end else begin
                  state_d  = ST_IDLE;
                  sda_oe_d = 1'b0;
               end
            end
            default: ;
         endcase
      end

      // Shift-load for a read byte; reading an input bank re-arms its
      // interrupt reference at the same instant the value is captured.
      if (w_load) begin
         shift_d  = w_rd_byte;
         sda_oe_d = ~w_rd_byte[7];
         for (int b = 0; b < N_BANKS; b++) begin
            if (w_valid && (w_kind == KIND_INPUT) && (w_bank == 2'(b))) begin
               snap_d[8*b +: 8] = gfilt_q[8*b +: 8];
            end
         end
      end
   end

   assign w_cfg_flat = cfg_q;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= ST_IDLE;
         bit_cnt_q <= 4'd0;
         shift_q   <= 8'h00;
         rw_q      <= 1'b0;
         mack_q    <= 1'b1;
         ptr_q     <= 8'h00;
         sda_oe_q  <= 1'b0;
         out_q     <= '1;
         pol_q     <= '0;
         cfg_q     <= '1;
         snap_q    <= gfilt_q;
         addr_q    <= addr_pins;
         int_n_q   <= 1'b1;
      end else begin
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         shift_q   <= shift_d;
         rw_q      <= rw_d;
         mack_q    <= mack_d;
         ptr_q     <= ptr_d;
         sda_oe_q  <= sda_oe_d;
         out_q     <= out_d;
         pol_q     <= pol_d;
         cfg_q     <= cfg_d;
         snap_q    <= snap_d;
         int_n_q   <= ~|((gfilt_q ^ snap_q) & w_cfg_flat);
      end
   end

   assign sda_oe  = sda_oe_q;
   assign gpio_o  = out_q;
   assign gpio_oe = ~w_cfg_flat;
   assign int_n   = int_n_q;

endmodule
`default_nettype wire

// File: tb/tb_i2c_gpio_expander.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2c_gpio_expander
// Purpose  : Directed self-checking bench for i2c_gpio_expander (N_BANKS=2,
//            address pins 3'b001 -> address byte 0x42/0x43).
// Revision : 1.0 - initial release
// ============================================================================
module tb_i2c_gpio_expander;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        scl = 1'b1;
   logic        m_sda = 1'b1;
   logic [2:0]  addr_pins = 3'b001;
   logic [15:0] gpio_i = 16'h12F0;
   logic        sda_oe;
   logic [15:0] gpio_o, gpio_oe;
   logic        int_n;
   wire         sda_bus = m_sda & ~sda_oe;

   int n_cmp = 0;
   int n_err = 0;
   int oe_cnt = 0;

   always #5 clk = ~clk;
   always @(posedge clk) if (sda_oe) oe_cnt <= oe_cnt + 1;

   i2c_gpio_expander #(.N_BANKS(2), .DEV_ADDR_HI(4'h4), .FILTER_LEN(3)) dut (
      .clk       (clk),
      .rst       (rst),
      .scl_i     (scl),
      .sda_i     (sda_bus),
      .sda_oe    (sda_oe),
      .addr_pins (addr_pins),
      .gpio_i    (gpio_i),
      .gpio_o    (gpio_o),
      .gpio_oe   (gpio_oe),
      .int_n     (int_n)
   );

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
      n_cmp++;
      assert (obs === exp_v) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   task automatic wclk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic i2c_start();
      m_sda = 1'b0; wclk(20); scl = 1'b0; wclk(10);
   endtask

   task automatic i2c_rstart();
      m_sda = 1'b1; wclk(10); scl = 1'b1; wclk(20);
      m_sda = 1'b0; wclk(20); scl = 1'b0; wclk(10);
   endtask

   task automatic i2c_stop();
      m_sda = 1'b0; wclk(10); scl = 1'b1; wclk(20); m_sda = 1'b1; wclk(20);
   endtask

   task automatic bit_out(input logic b, input bit glitch);
      m_sda = b; wclk(10); scl = 1'b1;
      if (glitch) begin
         wclk(5); m_sda = ~b; wclk(2); m_sda = b; wclk(13);
      end else begin
         wclk(20);
      end
      scl = 1'b0; wclk(10);
   endtask

   task automatic bit_in(output logic b);
      m_sda = 1'b1; wclk(10); scl = 1'b1; wclk(10);
      b = sda_bus; wclk(10); scl = 1'b0; wclk(10);
   endtask

   task automatic wr_byte(input logic [7:0] d, input bit glitch, output logic ack);
      for (int i = 7; i >= 0; i--) bit_out(d[i], glitch && (i == 7));
      bit_in(ack);
   endtask

   task automatic rd_byte(input logic nack, output logic [7:0] d);
      logic b;
      for (int i = 7; i >= 0; i--) begin
         bit_in(b);
         d[i] = b;
      end
      bit_out(nack, 1'b0);
   endtask

   // Returns OR of all ACK bits (0 = every byte ACKed)
   task automatic wr_reg(input logic [7:0] ptr, input logic [7:0] data, output logic nak);
      logic a0, a1, a2;
      i2c_start();
      wr_byte(8'h42, 1'b0, a0); wr_byte(ptr, 1'b0, a1); wr_byte(data, 1'b0, a2);
      i2c_stop();
      nak = a0 | a1 | a2;
   endtask

   task automatic rd_reg(input logic [7:0] ptr, output logic [7:0] d, output logic nak);
      logic a0, a1, a2;
      i2c_start();
      wr_byte(8'h42, 1'b0, a0); wr_byte(ptr, 1'b0, a1);
      i2c_rstart();
      wr_byte(8'h43, 1'b0, a2);
      rd_byte(1'b1, d);
      i2c_stop();
      nak = a0 | a1 | a2;
   endtask

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic       a, a1, a2, a3;
      logic [7:0] d, d1;
      int         oe_before;

      // ---- Reset state ----
      wclk(8);
      chk("rst_gpio_o", gpio_o, 16'hFFFF);
      chk("rst_gpio_oe", gpio_oe, 16'h0000);
      chk("rst_sda_oe", {15'd0, sda_oe}, 16'd0);
      chk("rst_int_n", {15'd0, int_n}, 16'd1);
      rst = 1'b1;
      wclk(10);

      // ---- Write with auto-increment ----
      i2c_start();
      wr_byte(8'h42, 1'b0, a);  chk("wr_ack_addr", {15'd0, a}, 16'd0);
      wr_byte(8'h04, 1'b0, a1); chk("wr_ack_ptr", {15'd0, a1}, 16'd0);
      wr_byte(8'hA5, 1'b0, a2); chk("wr_ack_d0", {15'd0, a2}, 16'd0);
      wr_byte(8'h3C, 1'b0, a3); chk("wr_ack_d1", {15'd0, a3}, 16'd0);
      i2c_stop();
      chk("wr_gpio_o", gpio_o, 16'h3CA5);

      // ---- Read input banks through polarity ----
      wr_reg(8'h08, 8'h0F, a);
      chk("pol_wr_ack", {15'd0, a}, 16'd0);
      i2c_start();
      wr_byte(8'h42, 1'b0, a); wr_byte(8'h00, 1'b0, a1);
      i2c_rstart();
      wr_byte(8'h43, 1'b0, a2);
      chk("rd_ack_addr", {15'd0, a | a1 | a2}, 16'd0);
      rd_byte(1'b0, d);
      rd_byte(1'b1, d1);
      chk("rd_bank0", {8'd0, d}, 16'h00FF);
      chk("rd_bank1", {8'd0, d1}, 16'h0012);
      chk("rd_sda_released", {15'd0, sda_oe}, 16'd0);
      i2c_stop();
      chk("rd_int_n", {15'd0, int_n}, 16'd1);

      // ---- Wrong address ----
      oe_before = oe_cnt;
      i2c_start();
      wr_byte(8'h50, 1'b0, a);  chk("bad_addr_nack", {15'd0, a}, 16'd1);
      wr_byte(8'h04, 1'b0, a1); chk("bad_addr_nack_b1", {15'd0, a1}, 16'd1);
      wr_byte(8'h77, 1'b0, a2); chk("bad_addr_nack_b2", {15'd0, a2}, 16'd1);
      i2c_stop();
      chk("bad_addr_no_drive", 16'(oe_cnt - oe_before), 16'd0);
      chk("bad_addr_gpio_o", gpio_o, 16'h3CA5);

      // ---- Invalid pointers ----
      wr_reg(8'h07, 8'h55, a);
      chk("inv07_wr_ack", {15'd0, a}, 16'd0);
      wr_reg(8'h14, 8'h55, a);
      chk("inv14_wr_ack", {15'd0, a}, 16'd0);
      chk("inv_gpio_o", gpio_o, 16'h3CA5);
      chk("inv_gpio_oe", gpio_oe, 16'h0000);
      rd_reg(8'h07, d, a);
      chk("inv07_rd", {7'd0, a, d}, 16'h00FF);
      rd_reg(8'h14, d, a);
      chk("inv14_rd", {7'd0, a, d}, 16'h00FF);

      // ---- Interrupt ----
      wr_reg(8'h0D, 8'h00, a);           // bank1 becomes outputs
      chk("cfg1_gpio_oe", {15'd0, a} | gpio_oe, 16'hFF00);
      gpio_i = 16'h12F8;
      wclk(6);
      chk("int_assert_6clk", {15'd0, int_n}, 16'd0);
      gpio_i = 16'h12F0;
      wclk(8);
      chk("int_pin_return", {15'd0, int_n}, 16'd1);
      gpio_i = 16'h12F8;
      wclk(8);
      chk("int_reassert", {15'd0, int_n}, 16'd0);
      rd_reg(8'h00, d, a);
      chk("int_rd_bank0", {7'd0, a, d}, 16'h00F7);
      chk("int_cleared", {15'd0, int_n}, 16'd1);
      gpio_i = 16'h13F8;                 // output-configured pin changes
      wclk(8);
      chk("int_masked", {15'd0, int_n}, 16'd1);

      // ---- Glitch rejection ----
      m_sda = 1'b0; wclk(2); m_sda = 1'b1; wclk(20);
      scl = 1'b0; wclk(10);
      wr_byte(8'h42, 1'b0, a);
      chk("glitch_no_start", {15'd0, a}, 16'd1);
      i2c_stop();
      i2c_start();
      wr_byte(8'h42, 1'b0, a); wr_byte(8'h04, 1'b0, a1);
      wr_byte(8'h00, 1'b1, a2);
      i2c_stop();
      chk("glitch_no_stop_ack", {15'd0, a | a1 | a2}, 16'd0);
      chk("glitch_no_stop_gpio", gpio_o, 16'h3C00);

      // ---- Reset mid-read ----
      i2c_start();
      wr_byte(8'h42, 1'b0, a); wr_byte(8'h04, 1'b0, a1);
      i2c_rstart();
      wr_byte(8'h43, 1'b0, a2);
      chk("mid_rd_driving", {14'd0, a | a1 | a2, sda_oe}, 16'd1);
      rst = 1'b0;
      wclk(1);
      chk("mid_rst_sda_oe", {15'd0, sda_oe}, 16'd0);
      m_sda = 1'b1; scl = 1'b1;
      wclk(4);
      chk("mid_rst_gpio_o", gpio_o, 16'hFFFF);
      chk("mid_rst_gpio_oe", gpio_oe, 16'h0000);
      rst = 1'b1;
      wclk(10);
      i2c_start();
      wr_byte(8'h43, 1'b0, a);
      rd_byte(1'b1, d);
      i2c_stop();
      chk("post_rst_ptr_rd", {7'd0, a, d}, 16'h00F8);
      chk("post_rst_int_n", {15'd0, int_n}, 16'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
